// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment scanner: per-digit dwell with anti-ghost blanking,
// frame-coherent capture of the character codes and blink mask, and per-digit blinking.
module seg_scan_driver #(
  parameter int unsigned DWELL_CYC    = 100000,
  parameter int unsigned BLANK_CYC    = 100,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [5:0] seg1,
  input  logic [5:0] seg2,
  input  logic [5:0] seg3,
  input  logic [5:0] seg4,
  input  logic [5:0] seg5,
  input  logic [5:0] seg6,
  input  logic [5:0] blink_mask,
  output logic [5:0] an,
  output logic [7:0] seg,
  output logic       frame_tick
);

  localparam int unsigned CntW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int unsigned FcW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CntW-1:0] CntLast  = CntW'(DWELL_CYC - 1);
  localparam logic [CntW-1:0] BlankCnt = CntW'(BLANK_CYC);
  localparam logic [FcW-1:0]  FcLast   = FcW'(BLINK_FRAMES - 1);
  localparam logic [2:0]      LastDig  = 3'd5;

  // Scan state
  logic [2:0]      dig_q, dig_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0][5:0] sh_q, sh_d;
  logic [5:0]      sh_mask_q, sh_mask_d;
  logic [FcW-1:0]  frame_cnt_q, frame_cnt_d;
  logic            phase_q, phase_d;
  logic            first_q, first_d;
  logic            capture;

  // Registered outputs
  logic [5:0] an_q, an_d;
  logic [7:0] seg_q, seg_d;
  logic       frame_tick_q, frame_tick_d;

  function automatic logic [7:0] font(input logic [5:0] c);
    logic [7:0] f;
    case (c)
      6'd0:  f = 8'h3F;
      6'd1:  f = 8'h06;
      6'd2:  f = 8'h5B;
      6'd3:  f = 8'h4F;
      6'd4:  f = 8'h66;
      6'd5:  f = 8'h6D;
      6'd6:  f = 8'h7D;
      6'd7:  f = 8'h07;
      6'd8:  f = 8'h7F;
      6'd9:  f = 8'h6F;
      6'd10: f = 8'h77;
      6'd11: f = 8'h7C;
      6'd12: f = 8'h39;
      6'd13: f = 8'h5E;
      6'd14: f = 8'h79;
      6'd15: f = 8'h71;
      6'd16: f = 8'h3D;
      6'd17: f = 8'h76;
      6'd18: f = 8'h30;
      6'd19: f = 8'h1E;
      6'd20: f = 8'h75;
      6'd21: f = 8'h38;
      6'd22: f = 8'h37;
      6'd23: f = 8'h54;
      6'd24: f = 8'h5C;
      6'd25: f = 8'h73;
      6'd26: f = 8'h67;
      6'd27: f = 8'h50;
      6'd28: f = 8'h6D;
      6'd29: f = 8'h78;
      6'd30: f = 8'h3E;
      6'd31: f = 8'h1C;
      6'd32: f = 8'h2A;
      6'd33: f = 8'h49;
      6'd34: f = 8'h6E;
      6'd35: f = 8'h5B;
      6'd36: f = 8'h40;
      6'd37: f = 8'h08;
      default: f = 8'h00;
    endcase
    return f;
  endfunction

  always_comb begin
    dig_d       = dig_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    sh_mask_d   = sh_mask_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    first_d     = first_q;
    capture     = 1'b0;

    if (!enable) begin
      dig_d   = '0;
      cnt_d   = '0;
      first_d = 1'b1;
    end else if (first_q) begin
      // Scan is already parked at (0,0); this edge only loads the first frame.
      capture = 1'b1;
      first_d = 1'b0;
    end else if (cnt_q != CntLast) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = '0;
      if (dig_q != LastDig) begin
        dig_d = dig_q + 3'd1;
      end else begin
        dig_d   = '0;
        capture = 1'b1;
        if (frame_cnt_q == FcLast) begin
          frame_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          frame_cnt_d = frame_cnt_q + FcW'(1);
        end
      end
    end

    if (capture) begin
      sh_d      = {seg6, seg5, seg4, seg3, seg2, seg1};
      sh_mask_d = blink_mask;
    end
  end

  // Outputs stay dark until the first frame has been captured.
  always_comb begin
    an_d         = '0;
    seg_d        = '0;
    frame_tick_d = 1'b0;
    if (enable && !first_q) begin
      seg_d        = font(sh_q[dig_q]);
      frame_tick_d = (dig_q == 3'd0) && (cnt_q == '0);
      if (!(cnt_q < BlankCnt) && !(phase_q && sh_mask_q[dig_q])) begin
        an_d = 6'b000001 << dig_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q        <= '0;
      cnt_q        <= '0;
      sh_q         <= {6{6'd63}};
      sh_mask_q    <= '0;
      frame_cnt_q  <= '0;
      phase_q      <= 1'b0;
      first_q      <= 1'b1;
      an_q         <= '0;
      seg_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      dig_q        <= dig_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      sh_mask_q    <= sh_mask_d;
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
      first_q      <= first_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: frame-offset reference model checked every cycle, a font
// vector table, and directed sequences for start-up, mid-frame changes, blink and resets.
module tb_seg_scan_driver;

  localparam int unsigned Dwell = 8;
  localparam int unsigned Blank = 2;
  localparam int unsigned BlinkFr = 2;
  localparam int Frame = 6 * Dwell;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [5:0] seg1 = '0, seg2 = '0, seg3 = '0, seg4 = '0, seg5 = '0, seg6 = '0;
  logic [5:0] blink_mask = '0;
  logic [5:0] an;
  logic [7:0] seg;
  logic       frame_tick;

  seg_scan_driver #(
    .DWELL_CYC   (Dwell),
    .BLANK_CYC   (Blank),
    .BLINK_FRAMES(BlinkFr)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .seg1      (seg1),
    .seg2      (seg2),
    .seg3      (seg3),
    .seg4      (seg4),
    .seg5      (seg5),
    .seg6      (seg6),
    .blink_mask(blink_mask),
    .an        (an),
    .seg       (seg),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] alnum [38];

  // Reference model: position within the frame, captured codes, total wraps since reset.
  bit         m_run;
  int         m_t;
  int         m_wraps;
  logic [5:0] m_codes [6];
  logic [5:0] m_mask;

  typedef struct {
    logic [5:0] code;
    logic [7:0] exp_seg;
  } font_vec_t;
  font_vec_t vecs [10];

  function automatic logic [7:0] font_ref(input logic [5:0] c);
    return (c < 6'd38) ? alnum[c] : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_t = 0;
    m_wraps = 0;
    m_mask = '0;
    for (int i = 0; i < 6; i++) m_codes[i] = 6'd63;
  endtask

  task automatic model_capture();
    m_codes[0] = seg1; m_codes[1] = seg2; m_codes[2] = seg3;
    m_codes[3] = seg4; m_codes[4] = seg5; m_codes[5] = seg6;
    m_mask = blink_mask;
  endtask

  task automatic model_edge(output logic [5:0] e_an, output logic [7:0] e_seg,
                            output logic e_ft);
    int d, p;
    bit blanked;
    e_an = '0; e_seg = '0; e_ft = 1'b0;
    if (enable && m_run) begin
      d = m_t / Dwell;
      p = m_t % Dwell;
      e_seg = font_ref(m_codes[d]);
      e_ft = (m_t == 0);
      blanked = (p < Blank) || ((((m_wraps / BlinkFr) % 2) == 1) && m_mask[d]);
      if (!blanked) e_an = 6'(1 << d);
    end
    if (!enable) begin
      m_run = 1'b0;
      m_t = 0;
    end else if (!m_run) begin
      model_capture();
      m_run = 1'b1;
      m_t = 0;
    end else begin
      m_t++;
      if (m_t == Frame) begin
        m_t = 0;
        m_wraps++;
        model_capture();
      end
    end
  endtask

  task automatic tick();
    logic [5:0] e_an;
    logic [7:0] e_seg;
    logic       e_ft;
    @(posedge clk);
    model_edge(e_an, e_seg, e_ft);
    @(negedge clk);
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("frame_tick", 32'(frame_tick), 32'(e_ft));
  endtask

  task automatic wait_ft(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_tick !== 1'b1 && n < 200);
    if (frame_tick !== 1'b1) chk("wait_frame_tick_timeout", 32'(frame_tick), 32'd1);
  endtask

  task automatic wait_an(input logic [5:0] target);
    int n = 0;
    do begin
      tick();
      n++;
    end while (an !== target && n < 200);
    if (an !== target) chk("wait_an_timeout", 32'(an), 32'(target));
  endtask

  task automatic set_codes(input logic [5:0] a, b, c, d, e, f);
    seg1 = a; seg2 = b; seg3 = c; seg4 = d; seg5 = e; seg6 = f;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [5:0] an_seq [8];
    bit saw0, saw2;
    bit exp_blink_on [6];

    alnum = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F,
              8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'h3D, 8'h76, 8'h30, 8'h1E,
              8'h75, 8'h38, 8'h37, 8'h54, 8'h5C, 8'h73, 8'h67, 8'h50, 8'h6D, 8'h78,
              8'h3E, 8'h1C, 8'h2A, 8'h49, 8'h6E, 8'h5B, 8'h40, 8'h08};
    vecs[0] = '{6'd0,  8'h3F};
    vecs[1] = '{6'd7,  8'h07};
    vecs[2] = '{6'd10, 8'h77};
    vecs[3] = '{6'd23, 8'h54};
    vecs[4] = '{6'd24, 8'h5C};
    vecs[5] = '{6'd35, 8'h5B};
    vecs[6] = '{6'd36, 8'h40};
    vecs[7] = '{6'd37, 8'h08};
    vecs[8] = '{6'd50, 8'h00};
    vecs[9] = '{6'd63, 8'h00};
    exp_blink_on = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset and idle
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_an", 32'(an), 32'd0);
    chk("idle_seg", 32'(seg), 32'd0);
    chk("idle_ft", 32'(frame_tick), 32'd0);

    // Start-up: load edge, then frame_tick with digit 0
    set_codes(6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5);
    enable = 1'b1;
    tick();
    chk("load_edge_ft", 32'(frame_tick), 32'd0);
    tick();
    chk("first_ft", 32'(frame_tick), 32'd1);
    chk("first_seg", 32'(seg), 32'h3F);
    for (int i = 0; i < 8; i++) begin
      an_seq[i] = an;
      tick();
    end
    for (int i = 0; i < 8; i++) chk("dwell0_an", 32'(an_seq[i]), (i < 2) ? 32'd0 : 32'd1);
    chk("dwell1_seg", 32'(seg), 32'h06);
    tick();
    tick();
    chk("dwell1_an", 32'(an), 32'b000010);

    // Frame period
    wait_ft(n);
    chk("to_next_frame", 32'(n), 32'(Frame - 10));
    wait_ft(n);
    chk("frame_period", 32'(n), 32'(Frame));

    // Mid-frame code change shows only from the next frame
    wait_an(6'b000010);
    seg3 = 6'd10;
    wait_an(6'b000100);
    chk("midframe_old", 32'(seg), 32'h5B);
    wait_an(6'b000010);
    wait_an(6'b000100);
    chk("nextframe_new", 32'(seg), 32'h77);
    wait_an(6'b010000);
    seg3 = 6'd2;
    wait_an(6'b000100);
    chk("dig4_change", 32'(seg), 32'h5B);

    // Enable drop mid-dwell on digit 3, then restart
    wait_an(6'b001000);
    enable = 1'b0;
    tick();
    chk("drop_an", 32'(an), 32'd0);
    chk("drop_seg", 32'(seg), 32'd0);
    tick();
    tick();
    seg1 = 6'd9;
    enable = 1'b1;
    tick();
    tick();
    chk("restart_ft", 32'(frame_tick), 32'd1);
    chk("restart_seg", 32'(seg), 32'h6F);

    // Asynchronous reset mid-frame
    wait_an(6'b000100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", 32'(an), 32'd0);
    chk("async_rst_seg", 32'(seg), 32'd0);
    model_reset();
    enable = 1'b0;
    set_codes(6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5);
    blink_mask = 6'b000100;
    @(negedge clk);
    rst_n = 1'b1;

    // Blink on digit 2: frames 0-1 on, 2-3 off, 4-5 on
    enable = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("blink_frame_ft", 32'(frame_tick), 32'd1);
      saw0 = 1'b0;
      saw2 = 1'b0;
      for (int i = 0; i < Frame; i++) begin
        saw0 |= an[0];
        saw2 |= an[2];
        tick();
      end
      chk("blink_dig0", 32'(saw0), 32'd1);
      chk("blink_dig2", 32'(saw2), 32'(exp_blink_on[k]));
    end

    // Font table
    blink_mask = '0;
    for (int v = 0; v < 10; v++) begin
      seg1 = vecs[v].code;
      wait_ft(n);
      wait_ft(n);
      chk("font", 32'(seg), 32'(vecs[v].exp_seg));
    end

    // Randomized run against the model
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 5))
          0: seg1 = 6'($urandom);
          1: seg2 = 6'($urandom);
          2: seg3 = 6'($urandom);
          3: seg4 = 6'($urandom);
          4: seg5 = 6'($urandom);
          default: seg6 = 6'($urandom);
        endcase
      end
      if ($urandom_range(0, 199) == 0) blink_mask = 6'($urandom);
      if (enable && $urandom_range(0, 299) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 4) == 0) enable = 1'b1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
